// File: rtl/ysyx_axi_sched_pkg.sv
// Shared types and AXI encodings for the single-outstanding IFU/LSU AXI scheduler.
package ysyx_axi_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_WR,
        S_B
    } state_e;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } owner_e;

    localparam int unsigned AXI_DATA_W = 64;
    localparam int unsigned AXI_STRB_W = 8;
    localparam int unsigned AXI_LEN_W  = 8;
    localparam int unsigned AXI_ID_W   = 4;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam logic [2:0] AXI_SIZE_1B = 3'b000;
    localparam logic [2:0] AXI_SIZE_2B = 3'b001;
    localparam logic [2:0] AXI_SIZE_4B = 3'b010;

    // Transfer size implied by an unshifted 32-bit store strobe.
    function automatic logic [2:0] strb_to_size(input logic [3:0] strb);
        case (strb)
            4'h1:    return AXI_SIZE_1B;
            4'h3:    return AXI_SIZE_2B;
            4'hF:    return AXI_SIZE_4B;
            default: return AXI_SIZE_1B;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_axi_wlane.sv
// Maps a 32-bit LSU store onto the 64-bit AXI write lanes (data, strobe, size).
module ysyx_axi_wlane
    import ysyx_axi_sched_pkg::*;
(
    input  logic [2:0]            addr_i,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            wstrb_i,
    output logic [AXI_DATA_W-1:0] wdata_c_o,
    output logic [AXI_STRB_W-1:0] wstrb_c_o,
    output logic [2:0]            awsize_c_o
);

    logic [31:0] shifted_data;
    logic [3:0]  shifted_strb;

    always_comb begin
        shifted_data = wdata_i << {addr_i[1:0], 3'b000};
        shifted_strb = wstrb_i << addr_i[1:0];
        wdata_c_o    = {shifted_data, shifted_data};
        wstrb_c_o    = addr_i[2] ? {shifted_strb, 4'h0} : {4'h0, shifted_strb};
        awsize_c_o   = strb_to_size(wstrb_i);
    end

endmodule

// File: rtl/ysyx_axi_sched.sv
// Arbitrates IFU fetches and LSU loads/stores onto one AXI master, one transaction at a time.
module ysyx_axi_sched
    import ysyx_axi_sched_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     ifu_araddr_i,
    input  logic                  ifu_arvalid_i,
    output logic [DATA_W-1:0]     ifu_rdata_o,
    output logic                  ifu_rvalid_o,
    input  logic [ADDR_W-1:0]     lsu_araddr_i,
    input  logic                  lsu_arvalid_i,
    input  logic [2:0]            lsu_rsize_i,
    output logic [DATA_W-1:0]     lsu_rdata_o,
    output logic                  lsu_rvalid_o,
    input  logic [ADDR_W-1:0]     lsu_awaddr_i,
    input  logic [DATA_W-1:0]     lsu_wdata_i,
    input  logic [3:0]            lsu_wstrb_i,
    input  logic                  lsu_wvalid_i,
    output logic                  lsu_wready_o,
    output logic [ADDR_W-1:0]     araddr_o,
    output logic [2:0]            arsize_o,
    output logic [AXI_LEN_W-1:0]  arlen_o,
    output logic [1:0]            arburst_o,
    output logic [AXI_ID_W-1:0]   arid_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic [AXI_DATA_W-1:0] rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rvalid_i,
    input  logic                  rlast_i,
    output logic                  rready_o,
    output logic [ADDR_W-1:0]     awaddr_o,
    output logic [2:0]            awsize_o,
    output logic [AXI_LEN_W-1:0]  awlen_o,
    output logic [AXI_ID_W-1:0]   awid_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [AXI_DATA_W-1:0] wdata_o,
    output logic [AXI_STRB_W-1:0] wstrb_o,
    output logic                  wvalid_o,
    output logic                  wlast_o,
    input  logic                  wready_i,
    input  logic [1:0]            bresp_i,
    input  logic                  bvalid_i,
    output logic                  bready_o,
    output logic                  bus_err_o
);

    localparam int unsigned SC_W = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_TOP = SC_W'(STARVE_MAX);

    state_e                state_q,   state_d;
    owner_e                owner_q,   owner_d;
    logic [ADDR_W-1:0]     addr_q,    addr_d;
    logic [2:0]            size_q,    size_d;
    logic [AXI_DATA_W-1:0] wdata_q,   wdata_d;
    logic [AXI_STRB_W-1:0] wstrb_q,   wstrb_d;
    logic [SC_W-1:0]       starve_q,  starve_d;
    logic                  arvalid_q, arvalid_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q,  wvalid_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q,  w_done_d;
    logic [DATA_W-1:0]     rdata_q,   rdata_d;
    logic                  ifu_rvalid_q, ifu_rvalid_d;
    logic                  lsu_rvalid_q, lsu_rvalid_d;
    logic                  lsu_wready_q, lsu_wready_d;
    logic                  bus_err_q,    bus_err_d;

    logic [AXI_DATA_W-1:0] lane_wdata;
    logic [AXI_STRB_W-1:0] lane_wstrb;
    logic [2:0]            lane_awsize;
    logic                  ifu_force;

    ysyx_axi_wlane u_wlane (
        .addr_i     (lsu_awaddr_i[2:0]),
        .wdata_i    (32'(lsu_wdata_i)),
        .wstrb_i    (lsu_wstrb_i),
        .wdata_c_o  (lane_wdata),
        .wstrb_c_o  (lane_wstrb),
        .awsize_c_o (lane_awsize)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_IFU;
            addr_q       <= '0;
            size_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            starve_q     <= '0;
            arvalid_q    <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            rdata_q      <= '0;
            ifu_rvalid_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            lsu_wready_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            starve_q     <= starve_d;
            arvalid_q    <= arvalid_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            rdata_q      <= rdata_d;
            ifu_rvalid_q <= ifu_rvalid_d;
            lsu_rvalid_q <= lsu_rvalid_d;
            lsu_wready_q <= lsu_wready_d;
            bus_err_q    <= bus_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        starve_d     = starve_q;
        arvalid_d    = arvalid_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        rdata_d      = rdata_q;
        ifu_rvalid_d = 1'b0;
        lsu_rvalid_d = 1'b0;
        lsu_wready_d = 1'b0;
        bus_err_d    = 1'b0;
        ifu_force    = ifu_arvalid_i && (starve_q == STARVE_TOP);

        case (state_q)
            S_IDLE: begin
                // A starved IFU overrides the normal store > load > fetch order.
                if (ifu_arvalid_i && (ifu_force || !(lsu_wvalid_i || lsu_arvalid_i))) begin
                    owner_d   = OWN_IFU;
                    addr_d    = ifu_araddr_i;
                    size_d    = AXI_SIZE_4B;
                    arvalid_d = 1'b1;
                    starve_d  = '0;
                    state_d   = S_AR;
                end else if (lsu_wvalid_i || lsu_arvalid_i) begin
                    owner_d = OWN_LSU;
                    if (ifu_arvalid_i && (starve_q != STARVE_TOP)) begin
                        starve_d = starve_q + SC_W'(1);
                    end
                    if (lsu_wvalid_i) begin
                        addr_d    = lsu_awaddr_i;
                        size_d    = lane_awsize;
                        wdata_d   = lane_wdata;
                        wstrb_d   = lane_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR;
                    end else begin
                        addr_d    = lsu_araddr_i;
                        size_d    = lsu_rsize_i;
                        arvalid_d = 1'b1;
                        state_d   = S_AR;
                    end
                end
            end
            S_AR: begin
                if (arready_i) begin
                    arvalid_d = 1'b0;
                    state_d   = S_R;
                end
            end
            S_R: begin
                if (rvalid_i && rlast_i) begin
                    rdata_d      = addr_q[2] ? DATA_W'(rdata_i[63:32]) : DATA_W'(rdata_i[31:0]);
                    ifu_rvalid_d = (owner_q == OWN_IFU);
                    lsu_rvalid_d = (owner_q == OWN_LSU);
                    bus_err_d    = (rresp_i != AXI_RESP_OKAY);
                    state_d      = S_IDLE;
                end
            end
            S_WR: begin
                // AW and W retire independently; B waits for both.
                aw_done_d = aw_done_q | (awvalid_q & awready_i);
                w_done_d  = w_done_q | (wvalid_q & wready_i);
                awvalid_d = awvalid_q & ~awready_i;
                wvalid_d  = wvalid_q & ~wready_i;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_B;
                end
            end
            S_B: begin
                if (bvalid_i) begin
                    lsu_wready_d = 1'b1;
                    bus_err_d    = (bresp_i != AXI_RESP_OKAY);
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ifu_rdata_o  = rdata_q;
    assign ifu_rvalid_o = ifu_rvalid_q;
    assign lsu_rdata_o  = rdata_q;
    assign lsu_rvalid_o = lsu_rvalid_q;
    assign lsu_wready_o = lsu_wready_q;
    assign bus_err_o    = bus_err_q;

    assign araddr_o  = addr_q;
    assign arsize_o  = size_q;
    assign arlen_o   = '0;
    assign arburst_o = AXI_BURST_INCR;
    assign arid_o    = '0;
    assign arvalid_o = arvalid_q;
    // Always accepting R/B lets beats of an abandoned transaction drain harmlessly.
    assign rready_o  = 1'b1;
    assign bready_o  = 1'b1;

    assign awaddr_o  = addr_q;
    assign awsize_o  = size_q;
    assign awlen_o   = '0;
    assign awid_o    = '0;
    assign awvalid_o = awvalid_q;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = wstrb_q;
    assign wvalid_o  = wvalid_q;
    assign wlast_o   = wvalid_q;

endmodule
